// File: rtl/puertas_pkg.sv
// Shared door encodings used by the door actuator and the upstream controller.
package puertas_pkg;

    // Door state encodings (also the value seen on puertas)
    localparam logic [1:0] CERRADAS = 2'b00;
    localparam logic [1:0] ABIERTAS = 2'b01;
    localparam logic [1:0] CERRANDO = 2'b10;
    localparam logic [1:0] ABRIENDO = 2'b11;

    // Door command encodings on salida_puertas
    localparam logic [1:0] CMD_NADA   = 2'b00;
    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

    // The unused command code 11 is folded onto "no command"
    function automatic logic [1:0] normalizar_cmd(input logic [1:0] cmd);
        return (cmd == 2'b11) ? CMD_NADA : cmd;
    endfunction

endpackage

// File: rtl/temporizador_puertas.sv
// Saturating dwell counter for the open-door timeout, with clear and enable.
module temporizador_puertas #(
    parameter int T_ESPERA = 8,
    localparam int EW = $clog2(T_ESPERA + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic limpiar,
    input  logic habilitar,
    output logic expirado
);

    localparam logic [EW:0] LIMITE = (EW + 1)'(T_ESPERA);

    logic [EW-1:0] espera;
    logic [EW:0]   siguiente;

    // One extra bit so espera+1 never overflows before the saturation compare
    assign siguiente = {1'b0, espera} + {{EW{1'b0}}, 1'b1};

    // Count while enabled, stick at T_ESPERA, flag expiry on the same edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            espera   <= '0;
            expirado <= 1'b0;
        end else if (limpiar) begin
            espera   <= '0;
            expirado <= 1'b0;
        end else if (habilitar) begin
            espera   <= (siguiente >= LIMITE) ? LIMITE[EW-1:0] : siguiente[EW-1:0];
            expirado <= (siguiente >= LIMITE);
        end
    end

endmodule

// File: rtl/motor_puertas.sv
// Door actuator model: travel counter, dwell timer and local safety reversal.
//
//  state    | meaning
//  CERRADAS | fully closed, pos = 0
//  ABRIENDO | opening, pos counts up towards T_MOVER
//  ABIERTAS | fully open, dwell timer running
//  CERRANDO | closing, pos counts down towards 0
module motor_puertas
    import puertas_pkg::*;
#(
    parameter int T_MOVER  = 4,
    parameter int T_ESPERA = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] salida_puertas,
    input  logic       sensor,
    output logic [1:0] puertas,
    output logic       timeout,
    output logic       cerrada_pulso
);

    localparam int PW = $clog2(T_MOVER + 1);
    localparam logic [PW-1:0] POS_MAX = PW'(T_MOVER);
    localparam logic [PW-1:0] POS_ULT = PW'(T_MOVER - 1);
    localparam logic [PW-1:0] POS_UNO = PW'(1);

    logic [PW-1:0] pos;
    logic [1:0]    cmd;
    logic          abrir;
    logic          cerrar;
    logic          limpiar_espera;
    logic          contar_espera;

    // Decode the command; 11 behaves as no command
    always_comb begin
        cmd    = normalizar_cmd(salida_puertas);
        abrir  = (cmd == CMD_ABRIR);
        cerrar = (cmd == CMD_CERRAR);
    end

    // Dwell timer runs only while open with no sensor and no command
    always_comb begin
        limpiar_espera = (puertas != ABIERTAS) || sensor || abrir || cerrar;
        contar_espera  = !limpiar_espera;
    end

    temporizador_puertas #(
        .T_ESPERA (T_ESPERA)
    ) u_temporizador (
        .clk       (clk),
        .reset     (reset),
        .limpiar   (limpiar_espera),
        .habilitar (contar_espera),
        .expirado  (timeout)
    );

    // State, position and closed-pulse registers. Completion uses >= / <= so a
    // reversal taken on the very first travel cycle can never step pos past its ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            puertas       <= CERRADAS;
            pos           <= '0;
            cerrada_pulso <= 1'b0;
        end else begin
            cerrada_pulso <= 1'b0;
            case (puertas)
                CERRADAS: begin
                    pos <= '0;
                    if (abrir) puertas <= ABRIENDO;
                end
                ABRIENDO: begin
                    if (cerrar && !sensor) begin
                        puertas <= CERRANDO;
                    end else if (pos >= POS_ULT) begin
                        puertas <= ABIERTAS;
                        pos     <= POS_MAX;
                    end else begin
                        pos <= pos + POS_UNO;
                    end
                end
                ABIERTAS: begin
                    pos <= POS_MAX;
                    if (!sensor && !abrir && cerrar) puertas <= CERRANDO;
                end
                CERRANDO: begin
                    if (sensor || abrir) begin
                        puertas <= ABRIENDO;
                    end else if (pos <= POS_UNO) begin
                        puertas       <= CERRADAS;
                        pos           <= '0;
                        cerrada_pulso <= 1'b1;
                    end else begin
                        pos <= pos - POS_UNO;
                    end
                end
                default: puertas <= CERRADAS;
            endcase
        end
    end

endmodule
